// File: rtl/xadc_pkg.sv
// Shared constants and types for the XADC DRP sampler.
package xadc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // DRP addresses of the auxiliary channels wired to the board.
  localparam logic [6:0] VAUX4  = 7'h14;
  localparam logic [6:0] VAUX12 = 7'h1C;

  // The conversion result sits left-justified in the 16-bit DRP word.
  localparam int RES_MSB = 15;
  localparam int RES_LSB = 4;

  // Width of the drdy wait timer; covers TIMEOUT up to 1023.
  localparam int TW = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a slow asynchronous level (e.g. a button).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two flops in series; the first may go metastable, the second settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/xadc_drp_sampler.sv
// Issues one DRP read per XADC end-of-conversion, then averages
// 2^AVG_LOG2 results from the same channel into a 12-bit sample.
module xadc_drp_sampler
  import xadc_pkg::*;
#(
  parameter int         AVG_LOG2 = 2,
  parameter logic [6:0] ADDR_A   = VAUX4,
  parameter logic [6:0] ADDR_B   = VAUX12,
  parameter int         TIMEOUT  = 255
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        eoc,
  input  logic        drdy,
  input  logic [15:0] do_in,
  output logic [6:0]  daddr,
  output logic        den,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        timeout_err
);

  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t          state, state_n;
  logic            sel_s;
  logic            ch;       // channel of the read in flight
  logic            win_ch;   // channel the accumulator belongs to
  logic [TW-1:0]   timer;
  logic [AW-1:0]   acc, acc_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [11:0]     res;
  logic            accept, take, expire;
  logic            unused_lsbs;

  // Low nibble of the DRP word carries no conversion data.
  assign unused_lsbs = ^do_in[RES_LSB-1:0];
  assign res         = do_in[RES_MSB:RES_LSB];

  sync_2ff u_sel_sync (
    .clk   (sysclk),
    .rst_n (rst_n),
    .d     (sel),
    .q     (sel_s)
  );

  // State register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and per-cycle events; eoc/drdy outside their states fall through.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    take    = 1'b0;
    expire  = 1'b0;
    case (state)
      IDLE: if (eoc) begin
        accept  = 1'b1;
        state_n = REQ;
      end
      REQ:  state_n = WAIT;
      WAIT: if (drdy) begin
        take    = 1'b1;
        state_n = IDLE;
      end else if (timer == TMAX) begin
        expire  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Accumulate into the current window, or restart it on a channel change.
  always_comb begin
    acc_n = AW'(res);
    cnt_n = CW'(1);
    if (ch == win_ch) begin
      acc_n = acc + AW'(res);
      cnt_n = cnt + CW'(1);
    end
  end

  // Request, timer, accumulator and output registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      daddr        <= ADDR_A;
      den          <= 1'b0;
      ch           <= 1'b0;
      win_ch       <= 1'b0;
      timer        <= '0;
      acc          <= '0;
      cnt          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      den          <= accept;
      sample_valid <= 1'b0;
      if (accept) begin
        ch    <= sel_s;
        daddr <= sel_s ? ADDR_B : ADDR_A;
      end
      if (state == REQ)       timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);
      if (expire) timeout_err <= 1'b1;
      if (take) begin
        win_ch <= ch;
        // count reaching 2^AVG_LOG2 is exactly its top bit being set
        if (cnt_n[AVG_LOG2]) begin
          sample       <= acc_n[AVG_LOG2 +: 12];
          sample_valid <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
        end else begin
          acc <= acc_n;
          cnt <= cnt_n;
        end
      end
    end
  end

endmodule

// File: doc/xadc_drp_sampler.md
# xadc_drp_sampler

DRP read sequencer and sample averager between the XADC wizard's DRP port and the LED PWM / `data_out` logic. On each end-of-conversion it issues one clean single-cycle DRP read to the channel chosen by the button. It captures the 12-bit result on `drdy` and averages 2^AVG_LOG2 reads. It then presents a stable 12-bit `sample` with a one-cycle `sample_valid`. It replaces the combinational `den = eoc` wiring and the negedge-`drdy` address mux with fully synchronous logic.

## Interface
- `AVG_LOG2`, 2: log2 of samples per average; legal range 0..4 (0 = pass-through).
- `ADDR_A`, 7'h14: DRP address used when `sel`=0 (VAUX4).
- `ADDR_B`, 7'h1C: DRP address used when `sel`=1 (VAUX12).
- `TIMEOUT`, 255: maximum cycles to wait for `drdy` after `den`; range 1..1023.

Ports:
- `sysclk` in 1: the only clock, 100 MHz, shared with the XADC `dclk_in`.
- `rst_n` in 1: asynchronous assert, active-low reset; deassertion is synchronized externally.
- `sel` in 1: raw button level; synchronized internally.
- `eoc` in 1: XADC `eoc_out`, a one-cycle pulse.
- `drdy` in 1: XADC `drdy_out`, a one-cycle pulse.
- `do_in` in 16: XADC `do_out`; result is in bits [15:4].
- `daddr` out 7: DRP address to the XADC.
- `den` out 1: DRP enable, a one-cycle pulse per read.
- `sample` out 12: averaged conversion; holds its value between updates.
- `sample_valid` out 1: one-cycle pulse when `sample` updates.
- `timeout_err` out 1: sticky flag; cleared only by reset.

## Operation
- Reset values:
  - state IDLE.
  - `daddr`=ADDR_A; `den`=0.
  - `sample`=0; `sample_valid`=0; `timeout_err`=0.
  - accumulator=0; count=0; `sel` synchronizer=0.
- FSM states:
  - IDLE: on `eoc`, latch the synchronized `sel` into `ch`, drive `daddr` to the address for `ch`, go to REQ.
  - REQ: one cycle; `den`=1; clear the timer; go to WAIT.
  - WAIT: on `drdy`, process the result and go to IDLE. If the timer reaches TIMEOUT first, set `timeout_err`, discard the read, go to IDLE.
- Processing a result:
  - If `ch` equals the channel of the current averaging window: add `do_in[15:4]` to the accumulator and increment count.
  - Otherwise: discard the accumulator, start a new window on `ch`, load this read as its first sample (count=1).
- Window complete (count = 2^AVG_LOG2): `sample` = accumulator >> AVG_LOG2 (truncating); pulse `sample_valid`; clear accumulator and count.
- Accumulator width is 12+AVG_LOG2 bits, so no overflow is possible.
- `eoc` outside IDLE is ignored. No queueing; the dropped conversion is simply lost.
- `drdy` outside WAIT is ignored.
- `daddr` is stable from REQ until the state returns to IDLE.
- `sel` changes take effect only at the next `eoc` accepted in IDLE.

## Timing
- `eoc` high in cycle t (state IDLE): `daddr` valid from t+1; `den`=1 in exactly cycle t+1.
- `drdy` high in cycle d: accumulator updated at the end of d.
- On a window-completing read: `sample` and `sample_valid` change in cycle d+1, with `sample_valid` high for exactly one cycle.
- Minimum spacing of accepted `eoc` pulses: 3 cycles (IDLE → REQ → WAIT → IDLE with an immediate `drdy`).
- `eoc` and `drdy` in the same cycle while in WAIT: the `drdy` is processed; the `eoc` is dropped.
- Timeout: with no `drdy`, `timeout_err` rises in cycle t+2+TIMEOUT and the state returns to IDLE.
  - A late `drdy` arriving after that point is ignored.
- `sel` synchronizer latency: 2 cycles.
- `rst_n` asserted mid-read: all outputs return to their reset values immediately (asynchronously). No `sample_valid` is emitted for the partial window.

## Structure
- Shared package `xadc_pkg`:
  - state enum (IDLE, REQ, WAIT).
  - DRP address constants (VAUX4 = 7'h14, VAUX12 = 7'h1C).
  - result slice constants (MSB 15, LSB 4).
- Sub-module `sync_2ff`: two-flop synchronizer for `sel`, reset to 0. Reusable for other buttons.
- Everything else (FSM, timer, accumulator, output registers) lives in a single module.

## Test plan
- Pass-through (AVG_LOG2=0, `sel`=0):
  - `eoc` at cycle 10 → `den` pulses at 11 with `daddr`=7'h14.
  - `drdy` at 15 with `do_in`=16'hABC0 → `sample`=12'hABC and `sample_valid` pulses at 16.
- Averaging (AVG_LOG2=2):
  - Four reads with results 12'h100, 12'h101, 12'h102, 12'h105 → exactly one `sample_valid`, with `sample`=12'h102 (sum 12'h408 >> 2).
- Channel switch mid-window:
  - Two reads on ADDR_A, then `sel`=1 before the third `eoc`.
  - Third read uses `daddr`=7'h1C and restarts the window.
  - `sample_valid` appears only after four ADDR_B reads.
- Timeout (TIMEOUT=8):
  - `eoc` with no `drdy` → `timeout_err`=1 at t+10; state returns to IDLE.
  - Next `eoc` produces a normal `den`; `timeout_err` stays 1.
- Dropped `eoc`:
  - `eoc` pulses at t and t+1 → exactly one `den`.
  - `eoc` coincident with `drdy` produces no `den`.
- Reset mid-window:
  - Assert `rst_n`=0 after two of four reads → `sample`=0, `daddr`=7'h14 immediately.
  - After release, four fresh reads are required before `sample_valid`.
